core_acc_collect: RTL

Output collector for the accumulation path. It receives the unthrottled single-cycle result pulses (`idata`/`idata_valid`) produced by the accumulation top, requantizes each signed result to `ODATA_BIT` bits (arithmetic shift plus saturation), and packs `PACK_NUM` results into one wide word. Packed words are buffered in a small FIFO and presented downstream on a valid/ready handshake. Because the accumulator cannot be back-pressured, overflow and saturation are reported through sticky flags and never stall the input.

---
 rtl/core_acc_collect.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/core_acc_collect.sv
// Accumulator output collector: requantizes signed results to ODATA_BIT lanes,
// packs PACK_NUM lanes per word and buffers words in a small valid/ready FIFO.
module core_acc_collect #(
  parameter int IDATA_BIT  = 32,
  parameter int ODATA_BIT  = 8,
  parameter int PACK_NUM   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CDATA_BIT  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CDATA_BIT-1:0]          cfg_shift,
  input  logic [IDATA_BIT-1:0]          idata,
  input  logic                          idata_valid,
  input  logic                          flush,
  input  logic                          clr_flag,
  output logic [PACK_NUM*ODATA_BIT-1:0] odata,
  output logic                          odata_valid,
  input  logic                          odata_ready,
  output logic                          ovf_flag,
  output logic                          sat_flag
);

  localparam int SHW = $clog2(IDATA_BIT);
  localparam int LW  = $clog2(PACK_NUM);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int WW  = PACK_NUM * ODATA_BIT;

  localparam logic signed [IDATA_BIT-1:0] QMAX =
    {{(IDATA_BIT-ODATA_BIT+1){1'b0}}, {(ODATA_BIT-1){1'b1}}};
  localparam logic signed [IDATA_BIT-1:0] QMIN = ~QMAX;

  typedef enum logic {
    EMPTY,
    FILL
  } pack_state_e;

  // ---------------------------------------------------------------- stage Q
  logic [SHW-1:0]                shamt;
  logic signed [IDATA_BIT-1:0]   shifted;
  logic [ODATA_BIT-1:0]          q_d, q_q;
  logic                          q_valid_q;
  logic                          sat_set;

  always_comb begin
    shamt = SHW'(cfg_shift);
    if (32'(cfg_shift) > 32'(IDATA_BIT - 1)) shamt = SHW'(IDATA_BIT - 1);
    shifted = $signed(idata) >>> shamt;
    q_d     = shifted[ODATA_BIT-1:0];
    sat_set = 1'b0;
    if (shifted > QMAX) begin
      q_d     = QMAX[ODATA_BIT-1:0];
      sat_set = idata_valid;
    end else if (shifted < QMIN) begin
      q_d     = QMIN[ODATA_BIT-1:0];
      sat_set = idata_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_valid_q <= idata_valid;
      if (idata_valid) q_q <= q_d;
    end
  end

  // ---------------------------------------------------------------- stage P
  pack_state_e     state_q, state_d;
  logic [LW-1:0]   lane_cnt_q, lane_cnt_d;
  logic [WW-1:0]   pack_q, pack_d, pack_wr;
  logic            last_lane;
  logic            push;

  // pack_wr is the word including this cycle's q write; it is also the push data
  always_comb begin
    pack_wr = pack_q;
    for (int unsigned i = 0; i < PACK_NUM; i++) begin
      if (q_valid_q && (lane_cnt_q == LW'(i))) pack_wr[i*ODATA_BIT +: ODATA_BIT] = q_q;
    end
    last_lane = q_valid_q && (lane_cnt_q == LW'(PACK_NUM - 1));
  end

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    pack_d     = pack_q;
    push       = 1'b0;
    unique case (state_q)
      EMPTY: begin
        // a single lane can never complete a word, so flush here emits it alone
        if (q_valid_q) begin
          if (flush) begin
            push = 1'b1;
          end else begin
            state_d    = FILL;
            lane_cnt_d = lane_cnt_q + LW'(1);
            pack_d     = pack_wr;
          end
        end
      end
      FILL: begin
        if (last_lane || flush) begin
          push       = 1'b1;
          state_d    = EMPTY;
          lane_cnt_d = '0;
          pack_d     = '0;
        end else if (q_valid_q) begin
          lane_cnt_d = lane_cnt_q + LW'(1);
          pack_d     = pack_wr;
        end
      end
      default: begin
        state_d    = EMPTY;
        lane_cnt_d = '0;
        pack_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      lane_cnt_q <= '0;
      pack_q     <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      pack_q     <= pack_d;
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          pop, full, push_acc, ovf_set;

  always_comb begin
    pop      = (count_q != '0) && odata_ready;
    full     = (count_q == CW'(FIFO_DEPTH));
    push_acc = push && (!full || pop);
    ovf_set  = push && full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_acc) begin
        mem_q[wptr_q] <= pack_wr;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push_acc) - CW'(pop);
    end
  end

  assign odata       = mem_q[rptr_q];
  assign odata_valid = (count_q != '0);

  // ---------------------------------------------------------------- flags
  logic ovf_q, sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q && !clr_flag) || ovf_set;
      sat_q <= (sat_q && !clr_flag) || sat_set;
    end
  end

  assign ovf_flag = ovf_q;
  assign sat_flag = sat_q;

endmodule
